// File: rtl/boot_uart_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : boot_uart_arbiter
//  Brief    : Routes the UART byte stream to the instruction-memory loader,
//             then to a CPU input FIFO once the program image is in place.
//  Revision : 1.0
// ============================================================================
module boot_uart_arbiter #(
  parameter int MEM_INST_SIZE = 1024,
  parameter int ADDR_W        = 10,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic [7:0]        in_data,
  output logic              in_valid,
  input  logic              in_ready,
  output logic              rx_overflow,
  output logic              load_error,
  output logic [1:0]        state
);

  localparam int                c_ptr_w     = $clog2(FIFO_DEPTH);
  localparam logic [31:0]       c_max_words = 32'(MEM_INST_SIZE);
  localparam logic [ADDR_W:0]   c_idx_one   = (ADDR_W+1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_ptr_w:0]  c_cnt_one   = (c_ptr_w+1)'(1);
  localparam logic [c_ptr_w:0]  c_fifo_full = (c_ptr_w+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_BODY = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_shift;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W:0]   r_word_idx;
  logic              r_run_pend;

  logic              w_loading;
  logic              w_byte_last;
  logic [31:0]       w_word;
  logic              w_hdr_zero;
  logic              w_hdr_big;
  logic [ADDR_W:0]   w_idx_inc;
  logic              w_body_done;

  assign w_loading   = (r_state == S_HDR) || (r_state == S_BODY);
  assign w_byte_last = rx_valid && w_loading && (r_byte_cnt == 2'd3);
  assign w_word      = {r_shift, rx_data};
  assign w_hdr_zero  = (w_word == 32'd0);
  assign w_hdr_big   = (w_word > c_max_words);
  assign w_idx_inc   = r_word_idx + c_idx_one;
  assign w_body_done = (w_idx_inc == r_words);
  assign state       = r_state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_HDR;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_byte_last) begin
          if (w_hdr_zero)     w_state_nxt = S_RUN;
          else if (w_hdr_big) w_state_nxt = S_ERR;
          else                w_state_nxt = S_BODY;
        end
      end
      S_BODY:  if (w_byte_last && w_body_done) w_state_nxt = S_RUN;
      default: w_state_nxt = r_state;
    endcase
  end

  // Loader datapath; cpu_run lags the final write pulse by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_words    <= '0;
      r_word_idx <= '0;
      r_run_pend <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_run    <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      r_run_pend <= (r_state == S_BODY) && w_byte_last && w_body_done;
      if (rx_valid && w_loading) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= {r_shift[15:0], rx_data};
      end
      if ((r_state == S_HDR) && w_byte_last) begin
        r_words    <= w_word[ADDR_W:0];
        r_word_idx <= '0;
      end
      if ((r_state == S_BODY) && w_byte_last) begin
        imem_we    <= 1'b1;
        imem_addr  <= r_word_idx[ADDR_W-1:0];
        imem_wdata <= w_word;
        r_word_idx <= w_idx_inc;
      end
      if (r_run_pend || ((r_state == S_HDR) && w_byte_last && w_hdr_zero))
        cpu_run <= 1'b1;
      if (w_state_nxt == S_ERR)
        load_error <= 1'b1;
    end
  end

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [c_ptr_w:0]   r_count, w_count_nxt;
  logic               w_run, w_full, w_pop, w_push, w_drop, w_bypass;
  logic [7:0]         w_head_nxt;

  assign w_run    = (r_state == S_RUN);
  assign w_full   = (r_count == c_fifo_full);
  assign w_pop    = in_valid && in_ready;
  assign w_push   = rx_valid && w_run && (!w_full || w_pop);
  assign w_drop   = rx_valid && w_run && w_full && !w_pop;
  // The incoming byte becomes head directly when nothing older remains.
  assign w_bypass = w_push && ((r_count == '0) || ((r_count == c_cnt_one) && w_pop));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + c_cnt_one;
    else if (w_pop && !w_push) w_count_nxt = r_count - c_cnt_one;
    w_rd_nxt   = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
    w_head_nxt = in_data;
    if (w_count_nxt != '0)
      w_head_nxt = w_bypass ? rx_data : r_mem[w_rd_nxt];
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      in_valid    <= 1'b0;
      in_data     <= 8'd0;
      rx_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      in_valid <= w_run && (w_count_nxt != '0);
      in_data  <= w_head_nxt;
      if (w_drop) rx_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boot_uart_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boot_uart_arbiter
//  Brief    : Directed self-checking bench for boot_uart_arbiter.
//  Revision : 1.0
// ============================================================================
module tb_boot_uart_arbiter;

  localparam int MEM_INST_SIZE = 1024;
  localparam int ADDR_W        = 10;
  localparam int FIFO_DEPTH    = 16;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready = 1'b0;
  logic              rx_overflow;
  logic              load_error;
  logic [1:0]        state;

  boot_uart_arbiter #(
    .MEM_INST_SIZE(MEM_INST_SIZE),
    .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rx_overflow(rx_overflow), .load_error(load_error),
    .state(state)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Write log, filled only by the monitor; tests read it relative to a base.
  int                wr_n = 0;
  logic [ADDR_W-1:0] wr_addr [2048];
  logic [31:0]       wr_data [2048];

  always @(negedge CLK) begin
    if (imem_we) begin
      wr_addr[wr_n] = imem_addr;
      wr_data[wr_n] = imem_wdata;
      wr_n = wr_n + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(imem_we),     32'd0);
    chk({tag, "_addr"},  32'(imem_addr),   32'd0);
    chk({tag, "_wdata"}, imem_wdata,       32'd0);
    chk({tag, "_run"},   32'(cpu_run),     32'd0);
    chk({tag, "_idata"}, 32'(in_data),     32'd0);
    chk({tag, "_ival"},  32'(in_valid),    32'd0);
    chk({tag, "_ovf"},   32'(rx_overflow), 32'd0);
    chk({tag, "_err"},   32'(load_error),  32'd0);
    chk({tag, "_state"}, 32'(state),       32'd0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    RST_N    = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    RST_N = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] w0;
    logic [31:0] w1;
    int          nwr;
    logic        run;
    logic        err;
    logic [1:0]  st;
  } vec_t;

  vec_t vt [6];

  initial begin
    int base;

    vt[0] = '{32'h0000_0002, 32'hDEAD_BEEF, 32'h0123_4567, 2, 1'b1, 1'b0, 2'd2};
    vt[1] = '{32'h0000_0000, 32'h0,         32'h0,         0, 1'b1, 1'b0, 2'd2};
    vt[2] = '{32'h0000_0401, 32'h0,         32'h0,         0, 1'b0, 1'b1, 2'd3};
    vt[3] = '{32'h0000_0001, 32'hCAFE_F00D, 32'h0,         1, 1'b1, 1'b0, 2'd2};
    vt[4] = '{32'hFFFF_FFFF, 32'h0,         32'h0,         0, 1'b0, 1'b1, 2'd3};
    vt[5] = '{32'h0001_0000, 32'h0,         32'h0,         0, 1'b0, 1'b1, 2'd3};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      in_ready = 1'b1;
      base = wr_n;
      send32(vt[i].hdr);
      if (vt[i].nwr > 0) send32(vt[i].w0);
      if (vt[i].nwr > 1) send32(vt[i].w1);
      tick();
      tick();
      chk("vec_nwr",   32'(wr_n - base),   32'(vt[i].nwr));
      if (vt[i].nwr > 0) begin
        chk("vec_addr0", 32'(wr_addr[base]), 32'd0);
        chk("vec_data0", wr_data[base],      vt[i].w0);
      end
      if (vt[i].nwr > 1) begin
        chk("vec_addr1", 32'(wr_addr[base+1]), 32'd1);
        chk("vec_data1", wr_data[base+1],      vt[i].w1);
      end
      chk("vec_run",   32'(cpu_run),    32'(vt[i].run));
      chk("vec_err",   32'(load_error), 32'(vt[i].err));
      chk("vec_state", 32'(state),      32'(vt[i].st));
      if (vt[i].err) begin
        send(8'h11); send(8'h22); send(8'h33);
        chk("err_ival",  32'(in_valid),     32'd0);
        tick();
        chk("err_nwr",   32'(wr_n - base),  32'd0);
        chk("err_run",   32'(cpu_run),      32'd0);
        chk("err_state", 32'(state),        32'd3);
      end
    end

    // Exact pulse and cpu_run timing for a two-word image.
    do_reset();
    send32(32'd2);
    send32(32'hDEAD_BEEF);
    chk("t_we0",   32'(imem_we),   32'd1);
    chk("t_addr0", 32'(imem_addr), 32'd0);
    chk("t_data0", imem_wdata,     32'hDEAD_BEEF);
    send(8'h01); send(8'h23); send(8'h45);
    chk("t_we_gap", 32'(imem_we),  32'd0);
    send(8'h67);
    chk("t_we1",   32'(imem_we),   32'd1);
    chk("t_addr1", 32'(imem_addr), 32'd1);
    chk("t_data1", imem_wdata,     32'h0123_4567);
    chk("t_run_early", 32'(cpu_run), 32'd0);
    tick();
    chk("t_we_off", 32'(imem_we),  32'd0);
    chk("t_run",   32'(cpu_run),   32'd1);

    // Empty image, then first FIFO byte latency.
    do_reset();
    in_ready = 1'b0;
    send32(32'd0);
    chk("z_run",  32'(cpu_run),  32'd1);
    chk("z_we",   32'(imem_we),  32'd0);
    chk("z_ival0", 32'(in_valid), 32'd0);
    send(8'h41);
    chk("z_ival", 32'(in_valid), 32'd1);
    chk("z_data", 32'(in_data),  32'h41);

    // Overflow: 17 bytes into a 16-deep FIFO with no pops.
    do_reset();
    in_ready = 1'b0;
    send32(32'd0);
    for (int b = 0; b < 17; b++) send(8'(b));
    chk("o_ovf",  32'(rx_overflow), 32'd1);
    chk("o_ival", 32'(in_valid),    32'd1);
    in_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      chk("o_pop_data",  32'(in_data),  32'(b));
      chk("o_pop_valid", 32'(in_valid), 32'd1);
      tick();
    end
    chk("o_empty", 32'(in_valid), 32'd0);
    in_ready = 1'b0;

    // Full FIFO with a simultaneous push and pop.
    do_reset();
    in_ready = 1'b0;
    send32(32'd0);
    for (int b = 0; b < 16; b++) send(8'hA0 + 8'(b));
    chk("f_ovf0", 32'(rx_overflow), 32'd0);
    chk("f_head", 32'(in_data),     32'hA0);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    in_ready = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("f_ovf1", 32'(rx_overflow), 32'd0);
    for (int b = 0; b < 15; b++) begin
      chk("f_pop_data", 32'(in_data), 32'hA1 + 32'(b));
      tick();
    end
    chk("f_last_data",  32'(in_data),  32'h55);
    chk("f_last_valid", 32'(in_valid), 32'd1);
    tick();
    chk("f_empty", 32'(in_valid), 32'd0);
    in_ready = 1'b0;

    // Reset in the middle of word 1 of a 3-word load, then a fresh image.
    do_reset();
    send32(32'd3);
    send32(32'h1111_1111);
    send(8'h22); send(8'h22);
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    RST_N = 1'b1;
    tick();
    base = wr_n;
    send32(32'd1);
    send32(32'h0BAD_C0DE);
    chk("m_we",   32'(imem_we),   32'd1);
    chk("m_addr", 32'(imem_addr), 32'd0);
    chk("m_data", imem_wdata,     32'h0BAD_C0DE);
    tick();
    chk("m_run",  32'(cpu_run),   32'd1);
    chk("m_nwr",  32'(wr_n - base), 32'd1);

    // Largest legal image: last write lands at MEM_INST_SIZE-1.
    do_reset();
    base = wr_n;
    send32(32'(MEM_INST_SIZE));
    for (int w = 0; w < MEM_INST_SIZE; w++) send32(32'h5A00_0000 | 32'(w));
    chk("b_we",   32'(imem_we),   32'd1);
    chk("b_addr", 32'(imem_addr), 32'(MEM_INST_SIZE - 1));
    chk("b_run_early", 32'(cpu_run), 32'd0);
    tick();
    chk("b_run",   32'(cpu_run),  32'd1);
    chk("b_nwr",   32'(wr_n - base), 32'(MEM_INST_SIZE));
    chk("b_first", wr_data[base], 32'h5A00_0000);
    chk("b_last",  wr_data[base + MEM_INST_SIZE - 1], 32'h5A00_03FF);
    chk("b_err",   32'(load_error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_uart_arbiter.md
# boot_uart_arbiter

Owns the UART receive byte stream and shares it between two consumers in sequence: first the instruction-memory loader phase, then the running CPU's input port. After reset it parses a length-prefixed program image, assembles big-endian 32-bit words and drives the instruction-memory write port. It then raises `cpu_run` and buffers every later byte in a FIFO that the CPU pops through a valid/ready handshake. It sits between the UART `receiver` and both the instruction memory and the core's `in` datapath.

## Interface
- `MEM_INST_SIZE`, 1024, instruction memory depth in words
- `ADDR_W`, 10, instruction address width; must equal clog2(MEM_INST_SIZE)
- `FIFO_DEPTH`, 16, CPU input FIFO depth in bytes; power of two, ≥2

- `CLK` in 1: single clock, all logic on posedge
- `RST_N` in 1: asynchronous, active-low reset
- `rx_data` in 8: received byte, valid only when `rx_valid`=1
- `rx_valid` in 1: one-cycle strobe per byte; may assert on consecutive cycles
- `imem_we` in/out: out 1: instruction memory write enable, one-cycle pulse per word
- `imem_addr` out ADDR_W: word address of the write
- `imem_wdata` out 32: word to write
- `cpu_run` out 1: program loaded; core may start fetching at address 0
- `in_data` out 8: FIFO head byte
- `in_valid` out 1: FIFO non-empty and state RUN
- `in_ready` in 1: CPU consumes head when `in_valid`&&`in_ready`
- `rx_overflow` out 1: sticky; a RUN-phase byte was dropped
- `load_error` out 1: sticky; header word count exceeded MEM_INST_SIZE
- `state` out 2: HDR=0, BODY=1, RUN=2, ERR=3 (debug)

## Operation
- Reset (`RST_N`=0, asynchronous): state HDR, byte counter 0, word index 0, FIFO empty. Outputs: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `in_data`=0, `in_valid`=0, `rx_overflow`=0, `load_error`=0.
- HDR: collect 4 bytes, MSB first, into a 32-bit count N.
  - On the 4th byte: if N=0 → RUN; if N>MEM_INST_SIZE → ERR; else → BODY with word index 0.
- BODY: collect 4 bytes per word, MSB first (byte0→[31:24] … byte3→[7:0]).
  - On each 4th byte, pulse `imem_we` with `imem_addr`=index and `imem_wdata`=assembled word, then increment the index.
  - After word N−1 is written → RUN.
- RUN: `cpu_run`=1 and stays 1 until reset. Each byte received is pushed into the FIFO.
- ERR: `load_error`=1. All bytes are ignored, `cpu_run` stays 0, and the block stays in ERR until reset.
- FIFO behaviour in RUN:
  - Pop when `in_valid`&&`in_ready`.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Full with no pop: the incoming byte is dropped and `rx_overflow` is set. Buffered contents are untouched.
  - Full with a simultaneous pop: the push is accepted.
  - Empty with a push: the byte is not poppable in that cycle.
- Bytes arriving in HDR/BODY never enter the FIFO. `in_ready` is ignored outside RUN.
- Reset asserted mid-load or mid-run aborts immediately. Partially assembled words are discarded, and the next image starts again from HDR.

## Timing
- All outputs are registered.
- `imem_we` is high for exactly the one cycle after the `rx_valid` cycle carrying a word's 4th byte. `imem_addr` and `imem_wdata` are stable in that cycle.
- `cpu_run` rises:
  - for N>0, in the cycle after the final `imem_we` pulse;
  - for N=0, in the cycle after the `rx_valid` carrying the 4th header byte.
- `load_error` and state ERR appear in the cycle after the 4th header byte.
- FIFO latency: a byte strobed in cycle t appears as `in_data` with `in_valid`=1 in cycle t+1, provided the FIFO was empty.
- After a pop in cycle t, the new head (or `in_valid`=0) is visible in cycle t+1.
- Sustained throughput: one byte per cycle in every state; no back-pressure toward the UART.
- Word index arithmetic is ADDR_W+1 bits wide, so N=MEM_INST_SIZE is legal with no wrap. The last write goes to address MEM_INST_SIZE−1.

## Test plan
- Header 00 00 00 02, then DE AD BE EF 01 23 45 67.
  - Two `imem_we` pulses: addr0=0xDEADBEEF, addr1=0x01234567.
  - `cpu_run` rises the cycle after the second pulse.
- Header 00 00 00 00.
  - No `imem_we`; `cpu_run`=1 one cycle after the 4th byte.
  - A following byte 0x41 yields `in_data`=0x41 with `in_valid`=1 the next cycle.
- Header 00 00 04 01 (1025 > 1024).
  - `load_error`=1, state=3, `cpu_run` stays 0.
  - Further bytes cause no writes and no FIFO activity.
- RUN with `in_ready`=0, push 17 bytes 0x00..0x10 back-to-back.
  - FIFO holds 0x00..0x0F and `rx_overflow`=1.
  - Raising `in_ready` pops exactly 16 bytes in order, then `in_valid`=0.
- RUN, FIFO full, push 0x55 in the same cycle as a pop: no overflow, and 0x55 is eventually delivered last.
- Assert `RST_N` low after 2 bytes of word 1 of a 3-word load.
  - All outputs return to reset values.
  - A fresh 1-word image then loads to addr0 and `cpu_run` rises.
